// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - register map, control bits, LFSR helpers and FSM states for the SID voice bank
package sid_pkg;

  localparam int OUT_W  = 12;
  localparam int LFSR_W = 23;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 23'h7FFFFF;

  // register offsets within one voice block
  localparam int REG_FREQ_LO = 0;
  localparam int REG_FREQ_HI = 1;
  localparam int REG_PW_LO   = 2;
  localparam int REG_PW_HI   = 3;
  localparam int REG_CTRL    = 4;

  // CTRL bit positions
  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  // LFSR feedback taps
  localparam int LFSR_FB_A = 22;
  localparam int LFSR_FB_B = 17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[LFSR_FB_A] ^ l[LFSR_FB_B]};
  endfunction

  // the eight LFSR bits that drive the noise waveform, MSB first
  function automatic logic [7:0] noise_taps(input logic [LFSR_W-1:0] l);
    return {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0]};
  endfunction

  // clear noise tap bits wherever the mixed output bit is low
  function automatic logic [LFSR_W-1:0] lfsr_lockup(input logic [LFSR_W-1:0] l,
                                                    input logic [7:0] m);
    logic [LFSR_W-1:0] r;
    r     = l;
    r[20] = l[20] & m[7];
    r[18] = l[18] & m[6];
    r[14] = l[14] & m[5];
    r[11] = l[11] & m[4];
    r[9]  = l[9]  & m[3];
    r[5]  = l[5]  & m[2];
    r[2]  = l[2]  & m[1];
    r[0]  = l[0]  & m[0];
    return r;
  endfunction

endpackage

// File: rtl/sid_wave_mix.sv
// rtl/sid_wave_mix.sv - combinational saw/tri/pulse/noise generation and AND mixer for one voice slice
module sid_wave_mix
  import sid_pkg::*;
(
  input  logic [12:0]      phase_top_i,  // new phase, MSB down to MSB-12
  input  logic [7:0]       noise_i,      // LFSR noise tap bits
  input  logic [11:0]      pw_i,
  input  logic [7:2]       ctrl_i,
  input  logic             src_msb_i,    // stored MSB of the ring-mod source voice
  output logic [OUT_W-1:0] wave_o
);

  logic [11:0] saw_w;
  logic [11:0] tri_w;
  logic [11:0] pulse_w;
  logic [11:0] noise_w;
  logic        tri_msb;
  logic        any_sel;

  // build each waveform and AND together the selected ones
  always_comb begin
    saw_w   = phase_top_i[12:1];
    tri_msb = phase_top_i[12] ^ (ctrl_i[CTRL_RING] & src_msb_i);
    tri_w   = tri_msb ? ~phase_top_i[11:0] : phase_top_i[11:0];
    pulse_w = (ctrl_i[CTRL_TEST] || (saw_w < pw_i)) ? 12'hFFF : 12'h000;
    noise_w = {noise_i, 4'b0000};
    wave_o  = 12'hFFF;
    any_sel = 1'b0;
    if (ctrl_i[CTRL_TRI]) begin
      wave_o  = wave_o & tri_w;
      any_sel = 1'b1;
    end
    if (ctrl_i[CTRL_SAW]) begin
      wave_o  = wave_o & saw_w;
      any_sel = 1'b1;
    end
    if (ctrl_i[CTRL_PULSE]) begin
      wave_o  = wave_o & pulse_w;
      any_sel = 1'b1;
    end
    if (ctrl_i[CTRL_NOISE]) begin
      wave_o  = wave_o & noise_w;
      any_sel = 1'b1;
    end
    if (!any_sel) begin
      wave_o = 12'h000;
    end
  end

endmodule

// File: rtl/sid_voice_bank.sv
// rtl/sid_voice_bank.sv - time-multiplexed SID oscillator bank; SID_VOICE_BANK_NOISE_LOCKUP_EN enables noise lockup
module sid_voice_bank
  import sid_pkg::*;
#(
  parameter int NUM_VOICES   = 3,
  parameter int ACC_W        = 24,
  parameter int NOISE_TAP    = 19,
  parameter int BASE_ADDR    = 0,
  parameter int VOICE_STRIDE = 7,
  parameter int ADDR_W       = 5
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          CLKen,
  input  logic                          WR,
  input  logic [ADDR_W-1:0]             ADDR,
  input  logic [7:0]                    DATA,
  output logic                          OUT_VALID,
  output logic [$clog2(NUM_VOICES)-1:0] OUT_VOICE,
  output logic [OUT_W-1:0]              OUTPUT,
  output logic                          OVERRUN
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int MSB     = ACC_W - 1;
  localparam logic [VOICE_W-1:0] LAST_V = VOICE_W'(NUM_VOICES - 1);

  state_e             state_q, state_d;
  logic [VOICE_W-1:0] v_q, v_d;
  logic               busy;
  logic               overrun_d;

  logic [ACC_W-1:0]      phase_q [NUM_VOICES];
  logic [LFSR_W-1:0]     lfsr_q  [NUM_VOICES];
  logic [15:0]           freq_q  [NUM_VOICES];
  logic [11:0]           pw_q    [NUM_VOICES];
  logic [7:1]            ctrl_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] edge_q;

  logic               out_valid_q;
  logic [VOICE_W-1:0] out_voice_q;
  logic [OUT_W-1:0]   output_q;
  logic               overrun_q;

  logic [VOICE_W-1:0] src_v;
  logic [7:1]         cur_ctrl;
  logic [ACC_W-1:0]   old_phase;
  logic [ACC_W-1:0]   new_phase;
  logic               msb_rise;
  logic [LFSR_W-1:0]  lfsr_shift;
  logic [LFSR_W-1:0]  lfsr_new;
  logic [OUT_W-1:0]   wave;

  // sequencer state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end

  // sequencer: one voice per RUN cycle; ticks arriving while busy are dropped and flagged
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    busy      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CLKen) begin
          state_d = ST_RUN;
          v_d     = '0;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        overrun_d = CLKen;
        if (v_q == LAST_V) begin
          state_d = ST_IDLE;
          v_d     = '0;
        end else begin
          v_d = v_q + VOICE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        v_d     = '0;
      end
    endcase
  end

  // shared phase adder, sync reset and LFSR clocking for the voice in the slot
  always_comb begin
    src_v     = (v_q == '0) ? LAST_V : v_q - VOICE_W'(1);
    cur_ctrl  = ctrl_q[v_q];
    old_phase = phase_q[v_q];
    new_phase = old_phase + ACC_W'(freq_q[v_q]);
    if (cur_ctrl[CTRL_TEST] || (cur_ctrl[CTRL_SYNC] && edge_q[src_v])) begin
      new_phase = '0;
    end
    msb_rise   = !old_phase[MSB] && new_phase[MSB];
    lfsr_shift = lfsr_q[v_q];
    if (cur_ctrl[CTRL_TEST]) begin
      lfsr_shift = LFSR_RESET;
    end else if (!old_phase[NOISE_TAP] && new_phase[NOISE_TAP]) begin
      lfsr_shift = lfsr_step(lfsr_q[v_q]);
    end
  end

  sid_wave_mix u_wave_mix (
    .phase_top_i (new_phase[MSB -: 13]),
    .noise_i     (noise_taps(lfsr_shift)),
    .pw_i        (pw_q[v_q]),
    .ctrl_i      (cur_ctrl[7:2]),
    .src_msb_i   (phase_q[src_v][MSB]),
    .wave_o      (wave)
  );

  // LFSR write-back value, optionally degraded by the mixed output
  always_comb begin
    lfsr_new = lfsr_shift;
`ifdef SID_VOICE_BANK_NOISE_LOCKUP_EN
    if (!cur_ctrl[CTRL_TEST] && cur_ctrl[CTRL_NOISE] &&
        (cur_ctrl[CTRL_TRI] || cur_ctrl[CTRL_SAW] || cur_ctrl[CTRL_PULSE])) begin
      lfsr_new = lfsr_lockup(lfsr_shift, wave[11:4]);
    end
`endif
  end

  // register file: decoded bus writes, unmapped addresses ignored
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i] <= '0;
        pw_q[i]   <= '0;
        ctrl_q[i] <= '0;
      end
    end else if (WR) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (int'(ADDR) == BASE_ADDR + i * VOICE_STRIDE + REG_FREQ_LO) freq_q[i][7:0]  <= DATA;
        if (int'(ADDR) == BASE_ADDR + i * VOICE_STRIDE + REG_FREQ_HI) freq_q[i][15:8] <= DATA;
        if (int'(ADDR) == BASE_ADDR + i * VOICE_STRIDE + REG_PW_LO)   pw_q[i][7:0]    <= DATA;
        if (int'(ADDR) == BASE_ADDR + i * VOICE_STRIDE + REG_PW_HI)   pw_q[i][11:8]   <= DATA[3:0];
        if (int'(ADDR) == BASE_ADDR + i * VOICE_STRIDE + REG_CTRL)    ctrl_q[i]       <= DATA[7:1];
      end
    end
  end

  // per-voice oscillator state, updated only in that voice's slot
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        lfsr_q[i]  <= LFSR_RESET;
      end
      edge_q <= '0;
    end else if (busy) begin
      phase_q[v_q] <= new_phase;
      lfsr_q[v_q]  <= lfsr_new;
      edge_q[v_q]  <= msb_rise;
    end
  end

  // output registers: sample held between valid pulses
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      output_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= busy;
      overrun_q   <= overrun_d;
      if (busy) begin
        out_voice_q <= v_q;
        output_q    <= wave;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_VOICE = out_voice_q;
  assign OUTPUT    = output_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_sid_voice_bank.sv
// tb/tb_sid_voice_bank.sv - self-checking bench for sid_voice_bank with a behavioural oscillator model
module tb_sid_voice_bank;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clken;
  logic        wr;
  logic [4:0]  addr;
  logic [7:0]  data;
  logic        out_valid;
  logic [1:0]  out_voice;
  logic [11:0] out_data;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  int unsigned m_phase [N];
  int unsigned m_lfsr  [N];
  bit          m_edge  [N];
  int unsigned m_freq  [N];
  int unsigned m_pw    [N];
  int unsigned m_ctrl  [N];
  int unsigned exp_out [N];
  logic [11:0] got_out [N];
  int          taps    [8] = '{20, 18, 14, 11, 9, 5, 2, 0};

  sid_voice_bank dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .CLKen     (clken),
    .WR        (wr),
    .ADDR      (addr),
    .DATA      (data),
    .OUT_VALID (out_valid),
    .OUT_VOICE (out_voice),
    .OUTPUT    (out_data),
    .OVERRUN   (overrun)
  );

  always #5 clk = ~clk;

  function automatic int unsigned bitof(input int unsigned x, input int b);
    return (x >> b) & 1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0; m_lfsr[v] = 'h7FFFFF; m_edge[v] = 0;
      m_freq[v] = 0; m_pw[v] = 0; m_ctrl[v] = 0;
    end
  endtask

  task automatic model_write(input int unsigned a, input int unsigned d);
    for (int v = 0; v < N; v++) begin
      int unsigned base;
      base = v * 7;
      if (a == base)     m_freq[v] = (m_freq[v] & 'hFF00) | d;
      if (a == base + 1) m_freq[v] = (m_freq[v] & 'h00FF) | (d << 8);
      if (a == base + 2) m_pw[v]   = (m_pw[v] & 'hF00) | d;
      if (a == base + 3) m_pw[v]   = (m_pw[v] & 'h0FF) | ((d & 'hF) << 8);
      if (a == base + 4) m_ctrl[v] = d & 'hFE;
    end
  endtask

  // one CLKen tick of the whole bank, voices in order 0..N-1
  task automatic model_tick();
    for (int v = 0; v < N; v++) begin
      int unsigned s, c, old, np, p, lower, tri_w, pulse_w, noise_w, mix, msb;
      bit test, any_sel;
      s = (v + N - 1) % N;
      c = m_ctrl[v];
      old = m_phase[v];
      test = bitof(c, 3);
      if (test || (bitof(c, 1) && m_edge[s])) np = 0;
      else np = (old + m_freq[v]) % 'h1000000;
      m_edge[v] = (old < 'h800000) && (np >= 'h800000);
      if (test) m_lfsr[v] = 'h7FFFFF;
      else if (bitof(old, 19) == 0 && bitof(np, 19) == 1)
        m_lfsr[v] = ((m_lfsr[v] << 1) | (bitof(m_lfsr[v], 22) ^ bitof(m_lfsr[v], 17))) & 'h7FFFFF;
      m_phase[v] = np;
      p = np >> 12;
      msb = bitof(np, 23) ^ (bitof(c, 2) & bitof(m_phase[s], 23));
      lower = (np >> 11) & 'hFFF;
      tri_w = msb ? (lower ^ 'hFFF) : lower;
      pulse_w = (test || p < m_pw[v]) ? 'hFFF : 0;
      noise_w = 0;
      for (int k = 0; k < 8; k++) noise_w |= bitof(m_lfsr[v], taps[k]) << (11 - k);
      mix = 'hFFF; any_sel = 0;
      if (bitof(c, 4)) begin mix &= tri_w;   any_sel = 1; end
      if (bitof(c, 5)) begin mix &= p;       any_sel = 1; end
      if (bitof(c, 6)) begin mix &= pulse_w; any_sel = 1; end
      if (bitof(c, 7)) begin mix &= noise_w; any_sel = 1; end
      if (!any_sel) mix = 0;
`ifdef SID_VOICE_BANK_NOISE_LOCKUP_EN
      if (!test && bitof(c, 7) && (c & 'h70) != 0)
        for (int k = 0; k < 8; k++)
          if (!bitof(mix, 11 - k)) m_lfsr[v] &= ~(32'd1 << taps[k]);
`endif
      exp_out[v] = mix;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; clken = 1'b0; wr = 1'b0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_reg(input int unsigned a, input int unsigned d);
    @(negedge clk);
    wr = 1'b1; addr = a[4:0]; data = d[7:0];
    @(negedge clk);
    wr = 1'b0;
    model_write(a, d);
  endtask

  // one tick; optional bus write held across the edge that ends voice 1's slot
  task automatic run_tick(input bit do_wr, input int unsigned wa, input int unsigned wd);
    bit lat_ok, ovr_seen;
    tick_no++;
    @(negedge clk); clken = 1'b1;
    @(negedge clk); clken = 1'b0;
    lat_ok = (out_valid === 1'b0);
    ovr_seen = (overrun !== 1'b0);
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      if (c <= N) begin
        if (out_valid !== 1'b1 || out_voice !== 2'(c - 1)) lat_ok = 0;
        got_out[c - 1] = out_data;
      end else if (out_valid !== 1'b0) lat_ok = 0;
      if (overrun !== 1'b0) ovr_seen = 1;
      if (c == 1 && do_wr) begin wr = 1'b1; addr = wa[4:0]; data = wd[7:0]; end
      if (c == 2 && do_wr) wr = 1'b0;
    end
    model_tick();
    if (do_wr) model_write(wa, wd);
    checks++;
    if (!lat_ok) begin
      errors++;
      $display("FAIL tick%0d_latency: valid/voice sequence got ok=%0d, required 1", tick_no, lat_ok);
    end
    checks++;
    if (ovr_seen) begin
      errors++;
      $display("FAIL tick%0d_overrun: OVERRUN seen=%0d, required 0", tick_no, ovr_seen);
    end
    for (int v = 0; v < N; v++) begin
      checks++;
      if (got_out[v] !== 12'(exp_out[v])) begin
        errors++;
        $display("FAIL tick%0d_v%0d_output: got %03h, required %03h", tick_no, v, got_out[v], exp_out[v]);
      end
    end
  endtask

  task automatic expect_out(input string name, input int v, input logic [11:0] need);
    checks++;
    if (got_out[v] !== need) begin
      errors++;
      $display("FAIL %s: got %03h, required %03h", name, got_out[v], need);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (out_voice !== 2'd0) begin errors++; $display("FAIL reset_voice: got %0d, required 0", out_voice); end
    checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL reset_output: got %03h, required 000", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
  endtask

  task automatic test_zero_regs();
    run_tick(0, 0, 0);
    for (int v = 0; v < N; v++) expect_out("zero_regs_out", v, 12'h000);
  endtask

  task automatic test_saw();
    write_reg(7, 'h00); write_reg(8, 'h10); write_reg(11, 'h20);
    repeat (16) run_tick(0, 0, 0);
    expect_out("saw_v1_tick16", 1, 12'h010);
    expect_out("saw_v0_idle", 0, 12'h000);
    expect_out("saw_v2_idle", 2, 12'h000);
  endtask

  task automatic test_sync();
    apply_reset();
    write_reg(0, 'hFF); write_reg(1, 'hFF);
    write_reg(7, 'h00); write_reg(8, 'h01); write_reg(11, 'h22);
    for (int t = 1; t <= 131; t++) begin
      run_tick(0, 0, 0);
      if (t == 128) expect_out("sync_v1_tick128", 1, 12'h008);
      if (t == 130) expect_out("sync_v1_tick130", 1, 12'h000);
      if (t == 131) expect_out("sync_v1_tick131", 1, 12'h000);
    end
  endtask

  task automatic test_noise();
    apply_reset();
    write_reg(18, 'h88);
    repeat (3) begin
      run_tick(0, 0, 0);
      expect_out("noise_test_ff0", 2, 12'hFF0);
    end
    write_reg(14, 'hFF); write_reg(15, 'hFF); write_reg(18, 'h80);
    for (int t = 1; t <= 10; t++) begin
      run_tick(0, 0, 0);
      if (t == 8) expect_out("noise_tick8_unshifted", 2, 12'hFF0);
      if (t == 9) expect_out("noise_tick9_first_shift", 2, 12'hFE0);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    logic ovr_a, ovr_b;
    write_reg(0, 'h00); write_reg(1, 'h40); write_reg(4, 'h20);
    write_reg(7, 'h45); write_reg(8, 'h23); write_reg(11, 'h10);
    write_reg(14, 'h00); write_reg(15, 'h90); write_reg(17, 'h08); write_reg(18, 'h40);
    @(negedge clk); clken = 1'b1;
    @(negedge clk);
    pulses = (out_valid === 1'b1) ? 1 : 0;
    @(negedge clk); clken = 1'b0;
    ovr_a = overrun;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) ovr_b = overrun;
      if (out_valid === 1'b1) begin
        pulses++;
        got_out[out_voice] = out_data;
      end
    end
    model_tick();
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b, required 1", ovr_a); end
    checks++; if (ovr_b !== 1'b0) begin errors++; $display("FAIL overrun_one_cycle: got %b, required 0", ovr_b); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL overrun_valid_count: got %0d, required 3", pulses); end
    for (int v = 0; v < N; v++) expect_out("overrun_tick_out", v, 12'(exp_out[v]));
    run_tick(0, 0, 0);
  endtask

  task automatic test_write_in_slot();
    write_reg(11, 'h20);
    run_tick(1, 8, 'h55);
    run_tick(0, 0, 0);
    run_tick(0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) begin
        int unsigned a, d;
        a = $urandom_range(0, 22);
        d = $urandom_range(0, 255);
        if ((a % 7) == 4 && a < 21 && $urandom_range(0, 7) != 0) d &= 'hF7;
        write_reg(a, d);
      end
      run_tick(0, 0, 0);
    end
  endtask

`ifdef SID_VOICE_BANK_NOISE_LOCKUP_EN
  task automatic test_lockup();
    apply_reset();
    write_reg(0, 'hFF); write_reg(1, 'hFF); write_reg(4, 'hA0);
    repeat (20) run_tick(0, 0, 0);
    expect_out("lockup_mix_zero", 0, 12'h000);
    write_reg(4, 'h80);
    run_tick(0, 0, 0);
    write_reg(4, 'h88);
    run_tick(0, 0, 0);
    expect_out("lockup_test_restores", 0, 12'hFF0);
    write_reg(4, 'h80);
    run_tick(0, 0, 0);
    expect_out("lockup_cleared_noise", 0, 12'hFF0);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_regs();
    test_saw();
    test_sync();
    test_noise();
    test_overrun();
    test_write_in_slot();
    test_random();
`ifdef SID_VOICE_BANK_NOISE_LOCKUP_EN
    test_lockup();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
